// File: rtl/ray_dispatcher_if.sv
// Avalon-MM master bus between the ray dispatcher and SDRAM.
// Signal names keep the original avm_m1_* port names.
interface ray_dispatcher_if;
  logic        avm_m1_read;
  logic        avm_m1_write;
  logic [31:0] avm_m1_address;
  logic [15:0] avm_m1_writedata;
  logic [1:0]  avm_m1_byteenable;
  logic [15:0] avm_m1_readdata;
  logic        avm_m1_readdatavalid;
  logic        avm_m1_waitrequest;

  modport master (
    output avm_m1_read, avm_m1_write, avm_m1_address, avm_m1_writedata, avm_m1_byteenable,
    input  avm_m1_readdata, avm_m1_readdatavalid, avm_m1_waitrequest
  );

  modport slave (
    input  avm_m1_read, avm_m1_write, avm_m1_address, avm_m1_writedata, avm_m1_byteenable,
    output avm_m1_readdata, avm_m1_readdatavalid, avm_m1_waitrequest
  );
endinterface

// File: rtl/ray_dispatcher.sv
// Ray batch controller: fetches each 6-dword ray record over a 16-bit AVMM
// master, launches the triangle intersector, waits for its finish and writes
// the 3-dword closest-hit record back. One ray in flight at a time.
module ray_dispatcher #(
  parameter int unsigned RAY_STRIDE = 24,
  parameter int unsigned RES_STRIDE = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  ray_baseaddr,
  input  logic [31:0]  ray_cnt,
  input  logic [31:0]  res_baseaddr,
  input  logic [31:0]  tri_cnt,
  output logic         busy,
  output logic         done,
  output logic         ins_ivalid,
  output logic [191:0] ins_ray,
  output logic [31:0]  ins_tri_cnt,
  input  logic         ins_hit,
  input  logic [31:0]  ins_t,
  input  logic [31:0]  ins_tri_index,
  input  logic         ins_finish,
  ray_dispatcher_if.master avm
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_LAUNCH, S_RUN, S_WR, S_NEXT, S_FIN
  } state_t;

  state_t         r_state;
  logic           r_busy;
  logic           r_done;
  logic           r_ivalid;
  logic [191:0]   r_ins_ray;
  logic [31:0]    r_tri_cnt;
  logic           r_read;
  logic           r_write;
  logic [31:0]    r_addr;
  logic [15:0]    r_wdata;
  logic [31:0]    r_ray_cnt;
  logic [31:0]    r_ray_ptr;   // byte address of the current ray record
  logic [31:0]    r_res_ptr;   // byte address of the current result record
  logic [31:0]    r_idx;       // ray index r
  logic [3:0]     r_h;         // halfword counter h
  logic [95:0]    r_rec;       // result record, word0 in [31:0]
  logic           r_first;     // first RUN cycle marker

  logic [3:0]     w_h_inc;
  logic [31:0]    w_rd_next_addr;
  logic [31:0]    w_wr_next_addr;
  logic [95:0]    w_miss_rec;
  logic [95:0]    w_cap_rec;

  assign w_h_inc        = r_h + 4'd1;
  assign w_rd_next_addr = r_ray_ptr + {27'b0, w_h_inc, 1'b0};
  assign w_wr_next_addr = r_res_ptr + {27'b0, w_h_inc, 1'b0};
  assign w_miss_rec     = {32'h0000_0000, 32'h7fff_ffff, 32'h0000_0000};
  assign w_cap_rec      = ins_hit ? {ins_tri_index, ins_t, 31'b0, 1'b1} : w_miss_rec;

  assign busy        = r_busy;
  assign done        = r_done;
  assign ins_ivalid  = r_ivalid;
  assign ins_ray     = r_ins_ray;
  assign ins_tri_cnt = r_tri_cnt;

  assign avm.avm_m1_read       = r_read;
  assign avm.avm_m1_write      = r_write;
  assign avm.avm_m1_address    = r_addr;
  assign avm.avm_m1_writedata  = r_wdata;
  assign avm.avm_m1_byteenable = 2'b11;

  // Batch FSM; every bus/intersector output is registered and set up on the
  // transition into the state that owns it, so it is valid for that whole state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ivalid  <= 1'b0;
      r_ins_ray <= '0;
      r_tri_cnt <= '0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ray_cnt <= '0;
      r_ray_ptr <= '0;
      r_res_ptr <= '0;
      r_idx     <= '0;
      r_h       <= '0;
      r_rec     <= '0;
      r_first   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_ray_cnt <= ray_cnt;
            r_tri_cnt <= tri_cnt;
            r_ray_ptr <= ray_baseaddr;
            r_res_ptr <= res_baseaddr;
            r_idx     <= '0;
            r_h       <= '0;
            r_busy    <= 1'b1;
            if (ray_cnt != 32'd0) begin
              r_read  <= 1'b1;
              r_addr  <= ray_baseaddr;
              r_state <= S_RD_REQ;
            end else begin
              r_state <= S_FIN;
            end
          end
        end

        S_RD_REQ: begin
          if (!avm.avm_m1_waitrequest) begin
            r_read  <= 1'b0;
            r_state <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (avm.avm_m1_readdatavalid) begin
            r_ins_ray[{r_h, 4'b0000} +: 16] <= avm.avm_m1_readdata;
            if (r_h == 4'd11) begin
              r_state <= S_LAUNCH;
            end else begin
              r_h     <= w_h_inc;
              r_read  <= 1'b1;
              r_addr  <= w_rd_next_addr;
              r_state <= S_RD_REQ;
            end
          end
        end

        // ins_ivalid is registered here, so it is high during the first RUN cycle.
        S_LAUNCH: begin
          r_h <= '0;
          if (r_tri_cnt == 32'd0) begin
            r_rec   <= w_miss_rec;
            r_write <= 1'b1;
            r_addr  <= r_res_ptr;
            r_wdata <= w_miss_rec[15:0];
            r_state <= S_WR;
          end else begin
            r_ivalid <= 1'b1;
            r_first  <= 1'b1;
            r_state  <= S_RUN;
          end
        end

        // finish may still be high from the previous ray during the launch cycle.
        S_RUN: begin
          r_ivalid <= 1'b0;
          r_first  <= 1'b0;
          if (!r_first && ins_finish) begin
            r_rec   <= w_cap_rec;
            r_h     <= '0;
            r_write <= 1'b1;
            r_addr  <= r_res_ptr;
            r_wdata <= w_cap_rec[15:0];
            r_state <= S_WR;
          end
        end

        S_WR: begin
          if (!avm.avm_m1_waitrequest) begin
            if (r_h == 4'd5) begin
              r_write <= 1'b0;
              r_state <= S_NEXT;
            end else begin
              r_h     <= w_h_inc;
              r_addr  <= w_wr_next_addr;
              r_wdata <= r_rec[{w_h_inc[2:0], 4'b0000} +: 16];
            end
          end
        end

        S_NEXT: begin
          r_idx <= r_idx + 32'd1;
          r_h   <= '0;
          if (r_idx + 32'd1 == r_ray_cnt) begin
            r_state <= S_FIN;
          end else begin
            r_ray_ptr <= r_ray_ptr + 32'(RAY_STRIDE);
            r_res_ptr <= r_res_ptr + 32'(RES_STRIDE);
            r_read    <= 1'b1;
            r_addr    <= r_ray_ptr + 32'(RAY_STRIDE);
            r_state   <= S_RD_REQ;
          end
        end

        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher: SDRAM/AVMM slave with random stalls
// and read latency, a behavioural intersector, and a per-batch reference model.
module tb_ray_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  ray_baseaddr = '0, ray_cnt = '0, res_baseaddr = '0, tri_cnt = '0;
  logic         busy, done, ins_ivalid;
  logic [191:0] ins_ray;
  logic [31:0]  ins_tri_cnt;

  ray_dispatcher_if avm ();

  // Slave / intersector model drive variables
  logic        m_wait = 1'b0, m_rdv = 1'b0;
  logic [15:0] m_rdata = '0;
  logic        m_fin = 1'b0, m_hit = 1'b0;
  logic [31:0] m_t = '0, m_idx = '0;

  assign avm.avm_m1_waitrequest   = m_wait;
  assign avm.avm_m1_readdatavalid = m_rdv;
  assign avm.avm_m1_readdata      = m_rdata;

  ray_dispatcher #(.RAY_STRIDE(24), .RES_STRIDE(12)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ray_baseaddr(ray_baseaddr), .ray_cnt(ray_cnt), .res_baseaddr(res_baseaddr), .tri_cnt(tri_cnt),
    .busy(busy), .done(done), .ins_ivalid(ins_ivalid), .ins_ray(ins_ray), .ins_tri_cnt(ins_tri_cnt),
    .ins_hit(m_hit), .ins_t(m_t), .ins_tri_index(m_idx), .ins_finish(m_fin),
    .avm(avm)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // SDRAM contents: a fixed function of the byte address and a per-batch salt.
  logic [15:0] salt = 16'h5a3c;
  function automatic logic [15:0] memf(input logic [31:0] a);
    return a[15:0] ^ {a[23:16], a[31:24]} ^ {a[6:0], a[15:7]} ^ salt;
  endfunction

  // AVMM slave: bounded waitrequest runs (<=5) and 1..8 cycle read latency.
  logic        stall_en = 1'b0;
  int          wait_run = 0, rv_cnt = 0;
  logic [31:0] rv_addr = '0;
  always @(posedge clk) begin
    if (stall_en && wait_run < 5 && $urandom_range(0, 2) != 0) begin
      m_wait <= 1'b1; wait_run <= wait_run + 1;
    end else begin
      m_wait <= 1'b0; wait_run <= 0;
    end
    m_rdv   <= 1'b0;
    m_rdata <= 16'($urandom);
    if (avm.avm_m1_read && !m_wait) begin
      rv_addr <= avm.avm_m1_address;
      rv_cnt  <= stall_en ? int'($urandom_range(1, 8)) : 1;
    end else if (rv_cnt == 1) begin
      m_rdv   <= 1'b1;
      m_rdata <= memf(rv_addr);
      rv_cnt  <= 0;
    end else if (rv_cnt > 1) begin
      rv_cnt <= rv_cnt - 1;
    end
  end

  // Intersector: answers for launch k of a batch come from hv_*[k].
  logic        hv_hit [16];
  logic [31:0] hv_t   [16];
  logic [31:0] hv_idx [16];
  int ins_total = 0, batch_base = 0, cur_i = 0, fin_cnt = 0;
  always @(posedge clk) begin
    if (ins_ivalid) begin
      m_fin     <= 1'b0;
      m_hit     <= 1'($urandom);
      m_t       <= $urandom;
      fin_cnt   <= int'($urandom_range(2, 7));
      cur_i     <= (ins_total - batch_base) % 16;
      ins_total <= ins_total + 1;
    end else if (fin_cnt == 1) begin
      m_fin   <= 1'b1;
      m_hit   <= hv_hit[cur_i];
      m_t     <= hv_t[cur_i];
      m_idx   <= hv_idx[cur_i];
      fin_cnt <= 0;
    end else if (fin_cnt > 1) begin
      fin_cnt <= fin_cnt - 1;
    end
  end

  // Bus / launch monitor, sampled on the falling edge.
  logic [31:0] q_rd [$];
  logic [47:0] q_wr [$];
  int          done_cnt = 0, launch_cnt = 0;
  logic [31:0] e_ray_base = '0, e_tri_cnt = '0;
  logic        p_stall = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  logic [31:0] p_addr = '0;
  logic [15:0] p_wd = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (avm.avm_m1_read || avm.avm_m1_write)
        check("rw_excl", 64'(avm.avm_m1_read & avm.avm_m1_write), 64'd0);
      if (p_stall) begin
        check("hold_rd", 64'(avm.avm_m1_read), 64'(p_rd));
        check("hold_wr", 64'(avm.avm_m1_write), 64'(p_wr));
        check("hold_addr", 64'(avm.avm_m1_address), 64'(p_addr));
        if (p_wr) check("hold_wdata", 64'(avm.avm_m1_writedata), 64'(p_wd));
      end
      p_stall = (avm.avm_m1_read || avm.avm_m1_write) && m_wait;
      p_rd    = avm.avm_m1_read;
      p_wr    = avm.avm_m1_write;
      p_addr  = avm.avm_m1_address;
      p_wd    = avm.avm_m1_writedata;
      if (avm.avm_m1_read && !m_wait) q_rd.push_back(avm.avm_m1_address);
      if (avm.avm_m1_write && !m_wait) q_wr.push_back({avm.avm_m1_address, avm.avm_m1_writedata});
      if (done) done_cnt++;
      if (ins_ivalid) begin
        logic [31:0]  a;
        logic [191:0] sh;
        a = e_ray_base + 32'(24 * (ins_total - batch_base));
        for (int w = 0; w < 6; w++) begin
          sh = ins_ray >> (32 * w);
          check("ins_ray", 64'(sh[31:0]),
                64'({memf(a + 32'(4 * w + 2)), memf(a + 32'(4 * w))}));
        end
        check("ins_tri_cnt", 64'(ins_tri_cnt), 64'(e_tri_cnt));
        launch_cnt++;
      end
    end else begin
      p_stall = 1'b0;
    end
  end

  task automatic rand_answers();
    for (int i = 0; i < 16; i++) begin
      hv_hit[i] = 1'($urandom);
      hv_t[i]   = $urandom;
      hv_idx[i] = $urandom;
    end
  endtask

  // One batch: drive start, wait for done, compare bus traffic with the model.
  task automatic run_batch(input string nm, input logic [31:0] rb, input logic [31:0] rc,
                           input logic [31:0] resb, input logic [31:0] tc,
                           input logic stl, input logic mid);
    int d0, l0, k, n;
    logic [31:0] ea, w[3];
    logic [15:0] ehw;
    stall_en = stl;
    batch_base = ins_total;
    e_ray_base = rb;
    e_tri_cnt  = tc;
    q_rd.delete();
    q_wr.delete();
    d0 = done_cnt;
    l0 = launch_cnt;
    ray_baseaddr = rb; ray_cnt = rc; res_baseaddr = resb; tri_cnt = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, ":busy_after_start"}, 64'(busy), 64'd1);
    for (k = 0; k < 6000; k++) begin
      if (done) break;
      if (mid && k == 40) begin
        start = 1'b1; ray_baseaddr = rb + 32'h100; ray_cnt = 32'd1; tri_cnt = 32'd0; res_baseaddr = '0;
      end
      if (mid && k == 41) start = 1'b0;
      @(negedge clk);
    end
    check({nm, ":done_seen"}, 64'(done), 64'd1);
    check({nm, ":busy_at_done"}, 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    stall_en = 1'b0;
    check({nm, ":done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({nm, ":launches"}, 64'(launch_cnt - l0), (tc != 0) ? 64'(rc) : 64'd0);
    // reads: 12 halfwords per ray, consecutive records RAY_STRIDE apart
    check({nm, ":n_reads"}, 64'(q_rd.size()), 64'(12 * rc));
    n = 0;
    for (int r = 0; r < int'(rc); r++)
      for (int h = 0; h < 12; h++) begin
        ea = rb + 32'(24 * r + 2 * h);
        if (n < q_rd.size()) check({nm, ":rd_addr"}, 64'(q_rd[n]), 64'(ea));
        n++;
      end
    // writes: 3-word record, low halfword of each word first
    check({nm, ":n_writes"}, 64'(q_wr.size()), 64'(6 * rc));
    n = 0;
    for (int r = 0; r < int'(rc); r++) begin
      if (tc != 0 && hv_hit[r]) begin
        w[0] = 32'd1; w[1] = hv_t[r]; w[2] = hv_idx[r];
      end else begin
        w[0] = 32'd0; w[1] = 32'h7fff_ffff; w[2] = 32'd0;
      end
      for (int h = 0; h < 6; h++) begin
        ea  = resb + 32'(12 * r + 2 * h);
        ehw = (h % 2 == 1) ? w[h / 2][31:16] : w[h / 2][15:0];
        if (n < q_wr.size()) check({nm, ":wr"}, 64'(q_wr[n]), 64'({ea, ehw}));
        n++;
      end
    end
  endtask

  logic [15:0] tbl_hit  [6] = '{16'h0001, 16'h0000, 16'h0000, 16'h0002, 16'h0002, 16'h0000};
  logic [15:0] tbl_miss [6] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0000};

  initial begin
    int d0, k;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ivalid", 64'(ins_ivalid), 64'd0);
    check("rst_ray_lo", 64'(ins_ray[63:0]), 64'd0);
    check("rst_ray_hi", 64'(ins_ray[191:128]), 64'd0);
    check("rst_tri_cnt", 64'(ins_tri_cnt), 64'd0);
    check("rst_read", 64'(avm.avm_m1_read), 64'd0);
    check("rst_write", 64'(avm.avm_m1_write), 64'd0);
    check("rst_addr", 64'(avm.avm_m1_address), 64'd0);
    check("rst_wdata", 64'(avm.avm_m1_writedata), 64'd0);
    check("byteenable", 64'(avm.avm_m1_byteenable), 64'd3);
    reset = 1'b0;
    @(negedge clk);

    // single ray, hit
    rand_answers();
    hv_hit[0] = 1'b1; hv_t[0] = 32'h0002_0000; hv_idx[0] = 32'd2;
    run_batch("hit1", 32'h1000, 32'd1, 32'h2000, 32'd4, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      if (i < q_wr.size()) check("hit1_halfword", 64'(q_wr[i][15:0]), 64'(tbl_hit[i]));

    // single ray, miss
    rand_answers();
    hv_hit[0] = 1'b0;
    run_batch("miss1", 32'h1000, 32'd1, 32'h2000, 32'd4, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      if (i < q_wr.size()) check("miss1_halfword", 64'(q_wr[i][15:0]), 64'(tbl_miss[i]));

    // tri_cnt = 0: no launches, two miss records
    rand_answers();
    run_batch("tri0", 32'h0000_5000, 32'd2, 32'h0000_6000, 32'd0, 1'b0, 1'b0);

    // ray_cnt = 0
    q_rd.delete(); q_wr.delete();
    d0 = done_cnt;
    ray_cnt = 32'd0; tri_cnt = 32'd3; start = 1'b1;
    check("rc0_busy_before", 64'(busy), 64'd0);
    @(negedge clk); start = 1'b0;
    check("rc0_busy_c1", 64'(busy), 64'd1);
    check("rc0_done_c1", 64'(done), 64'd0);
    @(negedge clk);
    check("rc0_busy_c2", 64'(busy), 64'd0);
    check("rc0_done_c2", 64'(done), 64'd1);
    @(negedge clk);
    check("rc0_done_c3", 64'(done), 64'd0);
    check("rc0_busy_c3", 64'(busy), 64'd0);
    check("rc0_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("rc0_bus_rd", 64'(q_rd.size()), 64'd0);
    check("rc0_bus_wr", 64'(q_wr.size()), 64'd0);

    // stalls, read latency, ignored mid-batch start
    salt = 16'h9e37;
    rand_answers();
    run_batch("stall3", 32'h0001_0000, 32'd3, 32'h0002_0000, 32'd7, 1'b1, 1'b1);

    // reset during RUN of ray 1 of 3, then a clean restart
    rand_answers();
    stall_en = 1'b0;
    batch_base = ins_total;
    e_ray_base = 32'h3000; e_tri_cnt = 32'd5;
    ray_baseaddr = 32'h3000; ray_cnt = 32'd3; res_baseaddr = 32'h4000; tri_cnt = 32'd5;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (k = 0; k < 3000; k++) begin
      if (ins_total - batch_base >= 2) break;
      @(negedge clk);
    end
    check("rstrun_reached", 64'(ins_total - batch_base), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    check("rstrun_read", 64'(avm.avm_m1_read), 64'd0);
    check("rstrun_write", 64'(avm.avm_m1_write), 64'd0);
    check("rstrun_busy", 64'(busy), 64'd0);
    check("rstrun_ivalid", 64'(ins_ivalid), 64'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    rand_answers();
    run_batch("restart", 32'h3000, 32'd3, 32'h4000, 32'd5, 1'b0, 1'b0);

    // random batches, including address wrap-around
    for (int b = 0; b < 4; b++) begin
      logic [31:0] rb, resb, rc, tc;
      salt = 16'($urandom);
      rand_answers();
      rc   = $urandom_range(1, 4);
      tc   = (b == 1) ? 32'd0 : $urandom_range(1, 9);
      rb   = (b == 2) ? 32'hFFFF_FFE8 : $urandom;
      resb = (b == 2) ? 32'hFFFF_FFF8 : $urandom;
      run_batch("rand", rb, rc, resb, tc, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
